// File: rtl/anita4_buffer_manager.sv
// Round-robin hold-buffer allocator for trigger digitization with holdoff and full-stall handling.
// Optional lost-trigger counter compiled in with `define ANITA4_LOST_TRIG_COUNT_EN.
module anita4_buffer_manager #(
  parameter  int unsigned NUM_BUF  = 4,
  parameter  int unsigned NUM_TRIG = 4,
  parameter  int unsigned HOLDOFF  = 8,
  localparam int unsigned BUF_BITS = $clog2(NUM_BUF)
) (
  input  logic                clk250_i,
  input  logic                rst_b_i,
  input  logic [NUM_TRIG-1:0] trig_i,
  input  logic                clear_i,
  input  logic [BUF_BITS-1:0] clear_buffer_i,
  output logic                digitize_o,
  output logic [BUF_BITS-1:0] digitize_buffer_o,
  output logic [NUM_TRIG-1:0] digitize_source_o,
  output logic [NUM_BUF-1:0]  buffer_status_o,
  output logic [NUM_BUF-1:0]  HOLD_o,
  output logic                dead_o,
  output logic [15:0]         lost_count_o
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLDOFF,
    S_FULL
  } state_e;

  state_e              state_q, state_d;
  logic [BUF_BITS-1:0] wp_q, wp_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_BUF-1:0]  status_q, status_d;
  logic                dig_q, dig_d;
  logic [BUF_BITS-1:0] dig_buf_q, dig_buf_d;
  logic [NUM_TRIG-1:0] dig_src_q, dig_src_d;
  logic                dead_q, dead_d;

  // Next-state: clear applies first so an acceptance on another buffer in the same cycle also lands
  always_comb begin
    state_d   = state_q;
    wp_d      = wp_q;
    cnt_d     = cnt_q;
    status_d  = status_q;
    dig_d     = 1'b0;
    dig_buf_d = dig_buf_q;
    dig_src_d = dig_src_q;

    if (clear_i) begin
      status_d[clear_buffer_i] = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (|trig_i) begin
          dig_d            = 1'b1;
          dig_buf_d        = wp_q;
          dig_src_d        = trig_i;
          status_d[wp_q]   = 1'b1;
          wp_d             = wp_q + BUF_BITS'(1);
          cnt_d            = CNT_W'(HOLDOFF - 1);
          state_d          = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt_q == '0) begin
          state_d = status_q[wp_q] ? S_FULL : S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_FULL: begin
        if (!status_q[wp_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    dead_d = (state_d != S_IDLE);
  end

`ifdef ANITA4_LOST_TRIG_COUNT_EN
  logic [15:0] lost_q, lost_d;

  // Saturating count of trigger cycles that arrive while dead
  always_comb begin
    lost_d = lost_q;
    if (dead_q && (|trig_i) && (lost_q != 16'hFFFF)) begin
      lost_d = lost_q + 16'd1;
    end
  end

  always_ff @(posedge clk250_i) begin
    if (!rst_b_i) begin
      lost_q <= '0;
    end else begin
      lost_q <= lost_d;
    end
  end

  assign lost_count_o = lost_q;
`else
  assign lost_count_o = '0;
`endif

  always_ff @(posedge clk250_i) begin
    if (!rst_b_i) begin
      state_q   <= S_IDLE;
      wp_q      <= '0;
      cnt_q     <= '0;
      status_q  <= '0;
      dig_q     <= 1'b0;
      dig_buf_q <= '0;
      dig_src_q <= '0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wp_q      <= wp_d;
      cnt_q     <= cnt_d;
      status_q  <= status_d;
      dig_q     <= dig_d;
      dig_buf_q <= dig_buf_d;
      dig_src_q <= dig_src_d;
      dead_q    <= dead_d;
    end
  end

  assign digitize_o        = dig_q;
  assign digitize_buffer_o = dig_buf_q;
  assign digitize_source_o = dig_src_q;
  assign buffer_status_o   = status_q;
  assign HOLD_o            = status_q;
  assign dead_o            = dead_q;

endmodule

// File: tb/tb_anita4_buffer_manager.sv
// Scoreboard bench: default-config instance plus an 8-buffer, holdoff-1 instance.
module tb_anita4_buffer_manager;

`ifdef ANITA4_LOST_TRIG_COUNT_EN
  localparam int LOST_EN = 1;
`else
  localparam int LOST_EN = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_b;
  logic [3:0]  a_trig, b_trig;
  logic        a_clr, b_clr;
  logic [1:0]  a_clr_buf;
  logic [2:0]  b_clr_buf;
  logic        a_dig, b_dig, a_dead, b_dead;
  logic [1:0]  a_dbuf;
  logic [2:0]  b_dbuf;
  logic [3:0]  a_dsrc, b_dsrc, a_stat, a_hold;
  logic [7:0]  b_stat, b_hold;
  logic [15:0] a_lost, b_lost;

  anita4_buffer_manager u_a (
    .clk250_i(clk), .rst_b_i(rst_b), .trig_i(a_trig), .clear_i(a_clr),
    .clear_buffer_i(a_clr_buf), .digitize_o(a_dig), .digitize_buffer_o(a_dbuf),
    .digitize_source_o(a_dsrc), .buffer_status_o(a_stat), .HOLD_o(a_hold),
    .dead_o(a_dead), .lost_count_o(a_lost)
  );

  anita4_buffer_manager #(.NUM_BUF(8), .NUM_TRIG(4), .HOLDOFF(1)) u_b (
    .clk250_i(clk), .rst_b_i(rst_b), .trig_i(b_trig), .clear_i(b_clr),
    .clear_buffer_i(b_clr_buf), .digitize_o(b_dig), .digitize_buffer_o(b_dbuf),
    .digitize_source_o(b_dsrc), .buffer_status_o(b_stat), .HOLD_o(b_hold),
    .dead_o(b_dead), .lost_count_o(b_lost)
  );

  typedef struct packed {
    logic [3:0] bufi;
    logic [3:0] src;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   errors = 0;
  int   checks = 0;
  logic prev_a = 1'b0;
  logic prev_b = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop expected digitize events whenever a DUT issues one
  always @(negedge clk) begin
    if (a_dig) begin
      chk("a_dig_not_consecutive", 32'(prev_a), 32'd0);
      if (qa.size() == 0) begin
        chk("a_dig_unexpected", 32'(a_dbuf), 32'hDEAD);
      end else begin
        ea = qa.pop_front();
        chk("a_dig_buffer", 32'(a_dbuf), 32'(ea.bufi));
        chk("a_dig_source", 32'(a_dsrc), 32'(ea.src));
      end
    end
    if (b_dig) begin
      chk("b_dig_not_consecutive", 32'(prev_b), 32'd0);
      if (qb.size() == 0) begin
        chk("b_dig_unexpected", 32'(b_dbuf), 32'hDEAD);
      end else begin
        eb = qb.pop_front();
        chk("b_dig_buffer", 32'(b_dbuf), 32'(eb.bufi));
        chk("b_dig_source", 32'(b_dsrc), 32'(eb.src));
      end
    end
    prev_a = a_dig;
    prev_b = b_dig;
  end

  task automatic chk_a_zero(input string tag);
    chk({tag, "_dig"},  32'(a_dig),  32'd0);
    chk({tag, "_dbuf"}, 32'(a_dbuf), 32'd0);
    chk({tag, "_dsrc"}, 32'(a_dsrc), 32'd0);
    chk({tag, "_stat"}, 32'(a_stat), 32'd0);
    chk({tag, "_hold"}, 32'(a_hold), 32'd0);
    chk({tag, "_dead"}, 32'(a_dead), 32'd0);
    chk({tag, "_lost"}, 32'(a_lost), 32'd0);
  endtask

  initial begin
    int dead_cnt;
    logic [3:0] src;
    rst_b = 1'b0; a_trig = '0; b_trig = '0; a_clr = 1'b0; b_clr = 1'b0;
    a_clr_buf = '0; b_clr_buf = '0;
    tick(); tick();
    rst_b = 1'b1;
    chk_a_zero("reset");

    // First trigger: buffer 0, then dead for exactly 8 cycles
    a_trig = 4'b0001; qa.push_back('{4'd0, 4'b0001});
    tick(); a_trig = '0;
    chk("first_hold", 32'(a_hold), 32'h1);
    chk("first_dead", 32'(a_dead), 32'd1);
    dead_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_dead) dead_cnt++;
      tick();
    end
    chk("holdoff_len", 32'(dead_cnt), 32'd8);

    // Fill remaining buffers 1..3, ten cycles apart
    for (int i = 1; i < 4; i++) begin
      src = 4'(1 << i);
      a_trig = src; qa.push_back('{4'(i), src});
      tick(); a_trig = '0;
      for (int j = 0; j < 9; j++) tick();
    end
    chk("full_stat", 32'(a_stat), 32'hF);
    chk("full_dead", 32'(a_dead), 32'd1);
    a_trig = 4'b0001;
    tick(); a_trig = '0;
    tick(); tick(); tick();
    chk("full_still_dead", 32'(a_dead), 32'd1);
    chk("full_lost1", 32'(a_lost), 32'(LOST_EN));

    // Clearing a non-wp buffer keeps the FSM stalled
    a_clr = 1'b1; a_clr_buf = 2'd2;
    tick(); a_clr = 1'b0;
    chk("clr2_stat", 32'(a_stat), 32'hB);
    tick(); tick(); tick();
    chk("clr2_dead", 32'(a_dead), 32'd1);

    // Clearing wp buffer with a same-cycle trigger: trigger lost, IDLE one cycle later
    a_clr = 1'b1; a_clr_buf = 2'd0; a_trig = 4'b0001;
    tick(); a_clr = 1'b0; a_trig = '0;
    chk("clr0_stat", 32'(a_stat), 32'hA);
    chk("clr0_dead_m1", 32'(a_dead), 32'd1);
    tick();
    chk("clr0_idle", 32'(a_dead), 32'd0);
    chk("clr0_lost2", 32'(a_lost), 32'(2 * LOST_EN));
    a_trig = 4'b0100; qa.push_back('{4'd0, 4'b0100});
    tick(); a_trig = '0;
    chk("realloc0_stat", 32'(a_stat), 32'hB);
    for (int j = 0; j < 12; j++) tick();
    chk("refull_dead", 32'(a_dead), 32'd1);

    // Reset during holdoff with two buffers held
    rst_b = 1'b0; tick(); tick(); rst_b = 1'b1;
    a_trig = 4'b0001; qa.push_back('{4'd0, 4'b0001});
    tick(); a_trig = '0;
    for (int j = 0; j < 9; j++) tick();
    a_trig = 4'b0010; qa.push_back('{4'd1, 4'b0010});
    tick(); a_trig = '0;
    chk("pre_rst_hold", 32'(a_hold), 32'h3);
    chk("pre_rst_dead", 32'(a_dead), 32'd1);
    rst_b = 1'b0; a_trig = 4'b0001; a_clr = 1'b1; a_clr_buf = 2'd1;
    tick(); rst_b = 1'b1; a_trig = '0; a_clr = 1'b0;
    chk_a_zero("mid_rst");
    a_trig = 4'b1000; qa.push_back('{4'd0, 4'b1000});
    tick(); a_trig = '0;
    chk("post_rst_hold", 32'(a_hold), 32'h1);

    // Held trigger for 18 cycles: two acceptances, 16 lost cycles
    rst_b = 1'b0; tick(); rst_b = 1'b1;
    a_trig = 4'b1000;
    qa.push_back('{4'd0, 4'b1000});
    qa.push_back('{4'd1, 4'b1000});
    for (int j = 0; j < 18; j++) tick();
    a_trig = '0;
    chk("held_lost", 32'(a_lost), 32'(16 * LOST_EN));
    chk("held_stat", 32'(a_stat), 32'h3);
    chk("held_idle", 32'(a_dead), 32'd0);

    // Trigger and clear of another buffer in the same cycle both apply
    a_trig = 4'b0010; a_clr = 1'b1; a_clr_buf = 2'd0;
    qa.push_back('{4'd2, 4'b0010});
    tick(); a_trig = '0; a_clr = 1'b0;
    chk("trig_clr_stat", 32'(a_stat), 32'h6);
    a_clr = 1'b1; a_clr_buf = 2'd3;
    tick(); a_clr = 1'b0;
    chk("clr_empty_stat", 32'(a_stat), 32'h6);
    chk("clr_empty_hold", 32'(a_hold), 32'h6);
    for (int j = 0; j < 10; j++) tick();

    // Eight-buffer, holdoff-1 instance: allocate 0..7 then stall
    rst_b = 1'b0; tick(); rst_b = 1'b1;
    for (int i = 0; i < 10; i++) begin
      src = 4'(1 << (i % 4));
      b_trig = src;
      if (i < 8) qb.push_back('{4'(i), src});
      tick(); b_trig = '0;
      tick();
    end
    chk("b_full_stat", 32'(b_stat), 32'hFF);
    chk("b_full_hold", 32'(b_hold), 32'hFF);
    chk("b_full_dead", 32'(b_dead), 32'd1);
    chk("b_lost", 32'(b_lost), 32'(2 * LOST_EN));

    tick(); tick();
    chk("a_queue_drained", 32'(qa.size()), 32'd0);
    chk("b_queue_drained", 32'(qb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
